// File: rtl/calc_op_sequencer.sv
// calc_op_sequencer
//   Command-side sequencer for the 8-bit combinational calculator. Commands
//   are queued in a small FIFO and driven onto the calculator one at a time.
//   Each operation's inputs are held for SETTLE cycles. The calculator's
//   result is then captured into a result register with its own handshake.
//
// Parameters
//   DEPTH   command FIFO entries (power of two, >= 2)
//   SETTLE  cycles the calculator inputs are held before capture (>= 1)
//
// Ports
//   clk, rst                  clock, synchronous active-high reset
//   cmd_valid/cmd_ready       command handshake; cmd_a, cmd_b, cmd_op payload
//   calc_a/calc_b/calc_opcode registered drive to the calculator
//   calc_out/calc_carry       calculator result inputs
//   res_valid/res_ready       result handshake
//   res_data/res_carry        captured result and carry
//   res_zero                  res_data == 0, computed locally
//   res_err                   divide-by-zero flag
//   res_tag                   sequence number of the originating command
//   busy                      FIFO non-empty or an operation in flight
module calc_op_sequencer #(
    parameter int DEPTH  = 4,
    parameter int SETTLE = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [7:0]  cmd_a,
    input  logic [7:0]  cmd_b,
    input  logic [2:0]  cmd_op,
    output logic [7:0]  calc_a,
    output logic [7:0]  calc_b,
    output logic [2:0]  calc_opcode,
    input  logic [15:0] calc_out,
    input  logic        calc_carry,
    output logic        res_valid,
    input  logic        res_ready,
    output logic [15:0] res_data,
    output logic        res_carry,
    output logic        res_zero,
    output logic        res_err,
    output logic [3:0]  res_tag,
    output logic        busy
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam int SET_W = (SETTLE > 1) ? $clog2(SETTLE) : 1;
    localparam int ENT_W = 4 + 3 + 8 + 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRIVE = 2'd1,
        HOLD  = 2'd2
    } state_t;

    // Entry layout: {tag, op, b, a}
    logic [ENT_W-1:0] fifo_mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;
    logic [3:0]       tag_ctr;
    logic [3:0]       cur_tag;
    logic [SET_W-1:0] settle_cnt;
    state_t           state;

    logic             full;
    logic             empty;
    logic             push;
    logic             pop;
    logic [ENT_W-1:0] head;
    logic             div_zero;
    logic [15:0]      cap_data;
    logic             cap_carry;

    assign full      = (count == CNT_W'(DEPTH));
    assign empty     = (count == '0);
    assign cmd_ready = !full && !rst;
    assign push      = cmd_valid && cmd_ready;
    assign pop       = (state == IDLE) && !empty;
    assign head      = fifo_mem[rd_ptr];
    assign busy      = !rst && (!empty || (state != IDLE));

    // Divide-by-zero is judged from the operands actually being driven, so
    // the calculator's output for that case never reaches the result.
    assign div_zero  = (calc_opcode == 3'b011) && (calc_b == 8'h00);
    assign cap_data  = div_zero ? 16'hFFFF : calc_out;
    assign cap_carry = div_zero ? 1'b0 : calc_carry;

    // Storage is payload only; occupancy is tracked by the pointers below.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr] <= {tag_ctr, cmd_op, cmd_b, cmd_a};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            count       <= '0;
            tag_ctr     <= 4'd0;
            cur_tag     <= 4'd0;
            settle_cnt  <= '0;
            state       <= IDLE;
            calc_a      <= 8'h00;
            calc_b      <= 8'h00;
            calc_opcode <= 3'b000;
            res_valid   <= 1'b0;
            res_data    <= 16'h0000;
            res_carry   <= 1'b0;
            res_zero    <= 1'b0;
            res_err     <= 1'b0;
            res_tag     <= 4'd0;
        end else begin
            if (push) begin
                wr_ptr  <= wr_ptr + PTR_W'(1);
                tag_ctr <= tag_ctr + 4'd1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase

            case (state)
                IDLE: begin
                    if (!empty) begin
                        calc_a      <= head[7:0];
                        calc_b      <= head[15:8];
                        calc_opcode <= head[18:16];
                        cur_tag     <= head[22:19];
                        settle_cnt  <= SET_W'(SETTLE - 1);
                        state       <= DRIVE;
                    end
                end
                DRIVE: begin
                    if (settle_cnt != '0) begin
                        settle_cnt <= settle_cnt - SET_W'(1);
                    end else begin
                        res_data  <= cap_data;
                        res_carry <= cap_carry;
                        res_zero  <= (cap_data == 16'h0000);
                        res_err   <= div_zero;
                        res_tag   <= cur_tag;
                        res_valid <= 1'b1;
                        state     <= HOLD;
                    end
                end
                HOLD: begin
                    if (res_ready) begin
                        res_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_calc_op_sequencer.sv
// tb_calc_op_sequencer
//   Directed bench for calc_op_sequencer. A behavioural calculator model is
//   attached to the calc_* port. Inputs change and outputs are
//   sampled on the falling clock edge.
module tb_calc_op_sequencer;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic [7:0]  cmd_a = 8'h00;
    logic [7:0]  cmd_b = 8'h00;
    logic [2:0]  cmd_op = 3'b000;
    logic [7:0]  calc_a;
    logic [7:0]  calc_b;
    logic [2:0]  calc_opcode;
    logic [15:0] calc_out;
    logic        calc_carry;
    logic        res_valid;
    logic        res_ready = 1'b0;
    logic [15:0] res_data;
    logic        res_carry;
    logic        res_zero;
    logic        res_err;
    logic [3:0]  res_tag;
    logic        busy;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;

    logic [15:0] got_d [5];
    logic [3:0]  got_t [5];
    int          got_c [5];
    int          got_n;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    calc_op_sequencer #(.DEPTH(4), .SETTLE(1)) dut (
        .clk         (clk),
        .rst         (rst),
        .cmd_valid   (cmd_valid),
        .cmd_ready   (cmd_ready),
        .cmd_a       (cmd_a),
        .cmd_b       (cmd_b),
        .cmd_op      (cmd_op),
        .calc_a      (calc_a),
        .calc_b      (calc_b),
        .calc_opcode (calc_opcode),
        .calc_out    (calc_out),
        .calc_carry  (calc_carry),
        .res_valid   (res_valid),
        .res_ready   (res_ready),
        .res_data    (res_data),
        .res_carry   (res_carry),
        .res_zero    (res_zero),
        .res_err     (res_err),
        .res_tag     (res_tag),
        .busy        (busy)
    );

    // Calculator model: add carry is bit 8 of the sum, sub carry is borrow.
    logic [15:0] m_a;
    logic [15:0] m_b;
    always_comb begin
        m_a        = {8'h00, calc_a};
        m_b        = {8'h00, calc_b};
        calc_out   = 16'h0000;
        calc_carry = 1'b0;
        case (calc_opcode)
            3'b000: begin calc_out = m_a + m_b; calc_carry = (m_a + m_b) > 16'h00FF; end
            3'b001: begin calc_out = m_a - m_b; calc_carry = (calc_a < calc_b); end
            3'b010: calc_out = m_a * m_b;
            3'b011: calc_out = (calc_b != 8'h00) ? (m_a / m_b) : 16'h0000;
            3'b100: calc_out = m_a ^ m_b;
            3'b101: calc_out = m_a * m_a;
            3'b110: calc_out = {8'h00, ~(calc_a & calc_b)};
            default: calc_out = m_a | m_b;
        endcase
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst       = 1'b1;
        cmd_valid = 1'b0;
        res_ready = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
    endtask

    // Called on a falling edge; returns on the falling edge after acceptance
    // with cmd_valid still high.
    task automatic push(input logic [7:0] a, input logic [7:0] b, input logic [2:0] op);
        int k;
        cmd_a     = a;
        cmd_b     = b;
        cmd_op    = op;
        cmd_valid = 1'b1;
        k = 0;
        while (!cmd_ready && k < 50) begin
            @(negedge clk);
            k++;
        end
        if (!cmd_ready) chk("push_timeout", 32'd0, 32'd1);
        @(negedge clk);
    endtask

    task automatic wait_res(input string name, input logic [15:0] d, input logic c,
                            input logic z, input logic e, input logic [3:0] t);
        int k;
        k = 0;
        while (!res_valid && k < 20) begin
            @(negedge clk);
            k++;
        end
        chk({name, "_valid"}, res_valid, 1);
        chk({name, "_data"},  res_data,  d);
        chk({name, "_carry"}, res_carry, c);
        chk({name, "_zero"},  res_zero,  z);
        chk({name, "_err"},   res_err,   e);
        chk({name, "_tag"},   res_tag,   t);
        res_ready = 1'b1;
        @(negedge clk);
        res_ready = 1'b0;
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int acc;
        int first_low;
        int unstable;
        int seen;
        int badctl;

        // ---------------- reset state ----------------
        @(negedge clk);
        @(negedge clk);
        @(negedge clk);
        chk("rst_cmd_ready", cmd_ready, 0);
        chk("rst_busy", busy, 0);
        rst = 1'b0;
        @(negedge clk);
        chk("rst_calc", {calc_a, calc_b, 5'd0, calc_opcode}, 0);
        chk("rst_res_valid", res_valid, 0);
        chk("rst_res", {res_data, res_carry, res_zero, res_err, res_tag}, 0);
        chk("idle_busy", busy, 0);
        chk("idle_cmd_ready", cmd_ready, 1);

        // ---------------- single add with exact latency ----------------
        push(8'd1, 8'd1, 3'b000);        // accepted at end of cycle T
        cmd_valid = 1'b0;                // now in T+1
        chk("t1_calc_a_early", calc_a, 0);
        chk("t1_res_valid_early", res_valid, 0);
        @(negedge clk);                  // T+2
        chk("t2_calc_a", calc_a, 1);
        chk("t2_calc_b", calc_b, 1);
        chk("t2_res_valid", res_valid, 0);
        @(negedge clk);                  // T+3
        chk("t3_res_valid", res_valid, 1);
        chk("t3_data", res_data, 16'h0002);
        chk("t3_carry", res_carry, 0);
        chk("t3_zero", res_zero, 0);
        chk("t3_tag", res_tag, 0);
        res_ready = 1'b1;
        @(negedge clk);
        res_ready = 1'b0;
        chk("t4_res_valid_cleared", res_valid, 0);

        // ---------------- back-to-back with res_ready high ----------------
        do_reset();
        res_ready = 1'b1;
        got_n = 0;
        fork
            begin
                push(8'd3, 8'd1, 3'b000);
                push(8'd1, 8'd3, 3'b000);
                push(8'd3, 8'd3, 3'b000);
                cmd_valid = 1'b0;
            end
            begin
                for (int k = 0; k < 20; k++) begin
                    if (res_valid && got_n < 3) begin
                        got_d[got_n] = res_data;
                        got_t[got_n] = res_tag;
                        got_c[got_n] = cyc;
                        got_n++;
                    end
                    @(negedge clk);
                end
            end
        join
        res_ready = 1'b0;
        chk("b2b_count", got_n, 3);
        chk("b2b_d0", got_d[0], 16'h0004);
        chk("b2b_d1", got_d[1], 16'h0004);
        chk("b2b_d2", got_d[2], 16'h0006);
        chk("b2b_t0", got_t[0], 0);
        chk("b2b_t1", got_t[1], 1);
        chk("b2b_t2", got_t[2], 2);
        chk("b2b_gap01", got_c[1] - got_c[0], 3);
        chk("b2b_gap12", got_c[2] - got_c[1], 3);

        // ---------------- divide ----------------
        do_reset();
        push(8'd8, 8'd0, 3'b011);
        cmd_valid = 1'b0;
        wait_res("div0", 16'hFFFF, 1'b0, 1'b0, 1'b1, 4'd0);
        push(8'd8, 8'd2, 3'b011);
        cmd_valid = 1'b0;
        wait_res("div2", 16'h0004, 1'b0, 1'b0, 1'b0, 4'd1);

        // ---------------- capacity with res_ready low ----------------
        do_reset();
        acc = 0;
        first_low = -1;
        unstable = 0;
        for (int k = 0; k < 12; k++) begin
            cmd_valid = 1'b1;
            cmd_a     = 8'(acc + 1);
            cmd_b     = 8'd1;
            cmd_op    = 3'b000;
            if (cmd_ready) acc++;
            else if (first_low < 0) first_low = k;
            if (res_valid && (res_data !== 16'h0002 || res_tag !== 4'd0)) unstable++;
            @(negedge clk);
        end
        cmd_valid = 1'b0;
        chk("cap_accepted", acc, 5);
        chk("cap_ready_low_cycle", first_low, 5);
        chk("cap_first_stable", unstable, 0);
        chk("cap_res_valid_held", res_valid, 1);
        res_ready = 1'b1;
        got_n = 0;
        for (int k = 0; k < 40; k++) begin
            if (res_valid && got_n < 5) begin
                got_d[got_n] = res_data;
                got_t[got_n] = res_tag;
                got_n++;
            end
            @(negedge clk);
        end
        res_ready = 1'b0;
        chk("drain_count", got_n, 5);
        for (int i = 0; i < 5; i++) begin
            chk($sformatf("drain_tag%0d", i), got_t[i], i);
            chk($sformatf("drain_data%0d", i), got_d[i], i + 2);
        end

        // ---------------- subtract wrap and zero result ----------------
        do_reset();
        push(8'd1, 8'd255, 3'b001);
        cmd_valid = 1'b0;
        wait_res("sub_wrap", 16'hFF02, 1'b1, 1'b0, 1'b0, 4'd0);
        push(8'd0, 8'd0, 3'b111);
        cmd_valid = 1'b0;
        wait_res("or_zero", 16'h0000, 1'b0, 1'b1, 1'b0, 4'd1);

        // ---------------- reset while driving ----------------
        do_reset();
        push(8'd1, 8'd1, 3'b000);
        push(8'd5, 8'd5, 3'b000);
        push(8'd2, 8'd2, 3'b000);
        push(8'd2, 8'd2, 3'b000);
        push(8'd2, 8'd2, 3'b000);
        cmd_valid = 1'b0;
        chk("mid_first_held", res_valid, 1);
        res_ready = 1'b1;
        @(negedge clk);
        res_ready = 1'b0;
        @(negedge clk);                  // second command now in DRIVE
        chk("mid_drive_calc_a", calc_a, 5);
        chk("mid_drive_busy", busy, 1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        seen = 0;
        badctl = 0;
        for (int k = 0; k < 8; k++) begin
            if (res_valid) seen++;
            if (busy || calc_a != 8'h00 || calc_b != 8'h00 || calc_opcode != 3'b000) badctl++;
            @(negedge clk);
        end
        chk("mid_no_result", seen, 0);
        chk("mid_idle_cleared", badctl, 0);
        push(8'd2, 8'd2, 3'b000);
        cmd_valid = 1'b0;
        wait_res("after_rst", 16'h0004, 1'b0, 1'b0, 1'b0, 4'd0);

        // ---------------- tag wrap ----------------
        do_reset();
        for (int i = 0; i < 17; i++) begin
            push(8'(i), 8'd1, 3'b000);
            cmd_valid = 1'b0;
            wait_res($sformatf("wrap%0d", i), 16'(i + 1), 1'b0, 1'b0, 1'b0, 4'(i));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
